echo_distance_filter: RTL and testbench

- Downstream consumer of the echo-duration counter in the ultrasonic path.
- Converts each captured echo pulse width (clk cycles) into centimetres with a sequential divider, then smooths it with a power-of-two moving average.
- Drives a hysteresis "near" flag that replaces the raw threshold into the LED/output stage.

---
 rtl/echo_distance_filter_if.sv | 24 ++
 rtl/echo_distance_filter.sv | 101 ++++++++++
 tb/tb_echo_distance_filter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/echo_distance_filter_if.sv
// Measurement bus between the echo-duration counter and echo_distance_filter.
// The counter side uses the master modport; the filter uses slave.
interface echo_distance_filter_if #(
    parameter int unsigned DIST_W = 9
);
    logic [31:0]       echo_duration;
    logic              dur_valid;
    logic              busy;
    logic [DIST_W-1:0] dist_raw;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_valid;
    logic              no_echo;
    logic              near;

    modport master (
        output echo_duration, dur_valid,
        input  busy, dist_raw, dist_cm, dist_valid, no_echo, near
    );

    modport slave (
        input  echo_duration, dur_valid,
        output busy, dist_raw, dist_cm, dist_valid, no_echo, near
    );
endinterface

// File: rtl/echo_distance_filter.sv
// Echo width -> cm via repeated subtraction, power-of-two moving average, hysteresis near flag.
// Define ECHO_FILTER_BYPASS_EN to drop the averaging buffer (dist_cm follows the raw value).
module echo_distance_filter #(
    parameter int unsigned CYCLES_PER_CM = 2900,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned DIST_W        = 9,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned NEAR_CM       = 20,
    parameter int unsigned HYST_CM       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    echo_distance_filter_if.slave bus
);
    localparam logic [31:0]       CPC   = 32'(CYCLES_PER_CM);
    localparam logic [DIST_W-1:0] MAX_Q = DIST_W'(MAX_CM);
    localparam logic [DIST_W-1:0] SET_V = DIST_W'(NEAR_CM);
    localparam logic [DIST_W-1:0] CLR_V = DIST_W'(NEAR_CM + HYST_CM);

    typedef enum logic [1:0] {IDLE, DIV, AVG, OUT} state_t;

    state_t            state;
    logic [31:0]       rem;
    logic [DIST_W-1:0] q;
    logic              no_echo_lat;
    logic [DIST_W-1:0] avg;

`ifndef ECHO_FILTER_BYPASS_EN
    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = DIST_W + AVG_LOG2;

    logic [DIST_W-1:0]   ring [DEPTH];
    logic [SUM_W-1:0]    sum;
    logic [AVG_LOG2-1:0] wptr;

    assign avg = DIST_W'(sum >> AVG_LOG2);
`else
    assign avg = q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rem            <= '0;
            q              <= '0;
            no_echo_lat    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.dist_raw   <= '0;
            bus.dist_cm    <= '0;
            bus.dist_valid <= 1'b0;
            bus.no_echo    <= 1'b0;
            bus.near       <= 1'b0;
`ifndef ECHO_FILTER_BYPASS_EN
            sum            <= '0;
            wptr           <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) ring[i] <= '0;
`endif
        end else begin
            bus.dist_valid <= 1'b0;
            bus.busy       <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.dur_valid) begin
                        // A zero width preloads q = MAX_CM so the DIV step exits at once,
                        // giving the same 3-cycle latency as a one-step division.
                        rem         <= bus.echo_duration;
                        no_echo_lat <= (bus.echo_duration == '0);
                        q           <= (bus.echo_duration == '0) ? MAX_Q : '0;
                        state       <= DIV;
                    end
                end
                DIV: begin
                    if (rem >= CPC && q < MAX_Q) begin
                        rem <= rem - CPC;
                        q   <= q + 1'b1;
                    end else begin
                        state <= AVG;
                    end
                end
                AVG: begin
`ifndef ECHO_FILTER_BYPASS_EN
                    sum        <= sum - SUM_W'(ring[wptr]) + SUM_W'(q);
                    ring[wptr] <= q;
                    wptr       <= wptr + 1'b1;
`endif
                    state <= OUT;
                end
                OUT: begin
                    bus.dist_raw   <= q;
                    bus.dist_cm    <= avg;
                    bus.no_echo    <= no_echo_lat;
                    bus.dist_valid <= 1'b1;
                    if (avg <= SET_V)      bus.near <= 1'b1;
                    else if (avg >= CLR_V) bus.near <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_echo_distance_filter.sv
// Directed plus randomized bench for echo_distance_filter against an arithmetic reference model.
// Honours ECHO_FILTER_BYPASS_EN in the model when the design is built with it.
module tb_echo_distance_filter;
    localparam int unsigned DIST_W = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    echo_distance_filter_if #(.DIST_W(DIST_W)) bus ();

    echo_distance_filter #(
        .CYCLES_PER_CM(2900),
        .MAX_CM       (400),
        .DIST_W       (DIST_W),
        .AVG_LOG2     (2),
        .NEAR_CM      (20),
        .HYST_CM      (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    int unsigned hist[$];
    bit          m_near;
    int unsigned m_q, m_avg, m_lat;
    bit          m_ne;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist   = '{0, 0, 0, 0};
        m_near = 1'b0;
    endtask

    task automatic model_sample(input logic [31:0] dur);
        int unsigned s;
        m_ne = (dur == 32'd0);
        if (m_ne) m_q = 400;
        else m_q = (dur / 32'd2900 > 32'd400) ? 400 : int'(dur / 32'd2900);
        m_lat = m_ne ? 3 : m_q + 3;
`ifdef ECHO_FILTER_BYPASS_EN
        m_avg = m_q;
`else
        hist.push_back(m_q);
        void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_avg = s / 4;
`endif
        if (m_avg <= 20) m_near = 1'b1;
        else if (m_avg >= 25) m_near = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_raw"},   bus.dist_raw,   0);
        check({tag, "_cm"},    bus.dist_cm,    0);
        check({tag, "_valid"}, bus.dist_valid, 0);
        check({tag, "_noecho"},bus.no_echo,    0);
        check({tag, "_near"},  bus.near,       0);
        check({tag, "_busy"},  bus.busy,       0);
    endtask

    // Waits for dist_valid; n is the edge index after the accepting edge (-1 on timeout).
    task automatic wait_valid(input int n0, output int n, output int bcnt);
        n    = -1;
        bcnt = 0;
        for (int i = n0; i <= 500; i++) begin
            @(posedge clk); #1;
            if (bus.busy) bcnt++;
            if (bus.dist_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_raw"},    bus.dist_raw, m_q);
        check({tag, "_cm"},     bus.dist_cm,  m_avg);
        check({tag, "_noecho"}, bus.no_echo,  m_ne);
        check({tag, "_near"},   bus.near,     m_near);
    endtask

    task automatic run(input string tag, input logic [31:0] dur, input bit gap);
        int n, b;
        bus.echo_duration = dur;
        bus.dur_valid     = 1'b1;
        @(posedge clk); #1;
        bus.dur_valid = 1'b0;
        model_sample(dur);
        wait_valid(1, n, b);
        check({tag, "_latency"}, n, m_lat);
        check({tag, "_busy_cycles"}, b, m_lat);
        check_outputs(tag);
        if (gap) begin
            @(posedge clk); #1;
            check({tag, "_pulse_end"}, bus.dist_valid, 0);
            check({tag, "_busy_end"},  bus.busy,       0);
            check({tag, "_hold_raw"},  bus.dist_raw,   m_q);
        end
    endtask

    initial begin
        int n, b, pulses;
        logic [31:0] d;

        rst               = 1'b1;
        bus.dur_valid     = 1'b0;
        bus.echo_duration = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill the buffer so that the abort below has something to clear.
        run("pre0", 32'd87000, 1'b1);
        run("pre1", 32'd87000, 1'b1);

        bus.echo_duration = 32'd29000;
        bus.dur_valid     = 1'b1;
        @(posedge clk); #1;
        bus.dur_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("abort");
        rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.dist_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);

        for (int i = 0; i < 4; i++) run($sformatf("q10_%0d", i), 32'd29000, 1'b1);
        for (int i = 0; i < 3; i++) run($sformatf("q30_%0d", i), 32'd87000, 1'b1);
        run("saturate", 32'hFFFF_FFFF, 1'b1);
        run("zero", 32'd0, 1'b1);

        // Second strobe while busy must be dropped.
        bus.echo_duration = 32'd29000;
        bus.dur_valid     = 1'b1;
        @(posedge clk); #1;
        bus.dur_valid = 1'b0;
        @(posedge clk); #1;
        bus.echo_duration = 32'd5800;
        bus.dur_valid     = 1'b1;
        @(posedge clk); #1;
        bus.dur_valid = 1'b0;
        model_sample(32'd29000);
        wait_valid(3, n, b);
        check("drop_latency", n, 13);
        check_outputs("drop");
        run("back_to_back", 32'd5800, 1'b0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.dist_valid) pulses++;
        end
        check("drop_no_extra_valid", pulses, 0);

        for (int i = 0; i < 12; i++) begin
            d = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 1200000));
            run($sformatf("rand%0d", i), d, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
